regfile_mp: RTL

- Parametrised multi-port integer register file; successor to the single-write/dual-read x0..x31 file.
- Adds configurable read and write port counts, RV32E depth, and optional write-to-read bypass.
- Adds a per-register scoreboard (pending-write busy bits) so a pipelined core can detect RAW hazards.
- Sits between decode/issue (reads, busy-set) and writeback (writes, busy-clear).

---
 rtl/core_pkg.sv | 18 +
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 65 ++++++
 rtl/regfile_mp.sv | 121 ++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants: architectural widths, register counts, address helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREG_I     = 32;
    localparam int NREG_E     = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // True for an address that names a real, writable register (not x0, inside the file).
    function automatic logic reg_valid(input reg_addr_t a, input int nreg);
        return (a != '0) && (int'(a) < nreg);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: read ports, write ports, issue/flush scoreboard controls.
// Latency: n/a (wiring only).
// Backpressure: none; every port is accepted every cycle.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1
);
    logic [NRD*core_pkg::REG_ADDR_W-1:0] rs_addr;
    logic [NRD*XLEN-1:0]                 rs_data;
    logic [NRD-1:0]                      rs_busy;
    logic [NWR-1:0]                      wr_en;
    logic [NWR*core_pkg::REG_ADDR_W-1:0] wr_addr;
    logic [NWR*XLEN-1:0]                 wr_data;
    logic                                iss_en;
    logic [core_pkg::REG_ADDR_W-1:0]     iss_addr;
    logic                                flush;

    // Pipeline side: issues reads, writebacks and scoreboard updates.
    modport master (
        output rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rs_data, rs_busy
    );

    // Register file side.
    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rs_data, rs_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write busy bits per register: set on issue, cleared on writeback, bulk-cleared on flush.
// Latency: updates take effect on the next rising edge; busy lookup is combinational.
// Backpressure: none; issue, write and flush are accepted every cycle.
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iss_en,
    input  reg_addr_t                  iss_addr,
    input  logic                       flush,
    input  logic [NREG-1:0]            wr_clr,
    input  logic [NRD*REG_ADDR_W-1:0]  rs_addr,
    input  logic [NRD-1:0]             rd_hit,
    output logic [NRD-1:0]             rs_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next busy vector: flush first, then writeback clears, then the issue set (set wins).
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end
        busy_d = busy_d & ~wr_clr;
        for (int k = 1; k < NREG; k++) begin
            if (iss_en && (iss_addr == REG_ADDR_W'(k))) begin
                busy_d[k] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Busy state register, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per-port lookup; out-of-range addresses and x0 never match, so they read not-busy.
    always_comb begin
        rs_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int k = 1; k < NREG; k++) begin
                if (rs_addr[i*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(k)) begin
                    rs_busy[i] = busy_q[k];
                end
            end
            // A write landing this cycle resolves the hazard when it is forwarded.
            if ((BYPASS != 0) && rd_hit[i]) begin
                rs_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file (x0 hardwired zero) with optional write bypass and RAW scoreboard.
// Latency: reads combinational (0 cycles); writes and busy updates visible after one rising edge.
// Backpressure: none; all read, write, issue and flush requests are accepted every cycle.
module regfile_mp
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave rf
);

    reg_addr_t         rd_a [NRD];
    reg_addr_t         wa   [NWR];
    logic [XLEN-1:0]   wd   [NWR];
    logic [NWR-1:0]    wv;
    logic [NREG-1:0]   wr_clr;
    logic [NRD-1:0]    rd_hit;
    logic [XLEN-1:0]   byp  [NRD];
    logic [XLEN-1:0]   regs [1:NREG-1];
    logic [NRD*XLEN-1:0] rs_data_c;
    logic [NRD-1:0]    rs_busy_c;

    // Split the flat port buses into per-port fields and qualify each write.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_a[i] = rf.rs_addr[i*REG_ADDR_W +: REG_ADDR_W];
        end
        for (int j = 0; j < NWR; j++) begin
            wa[j] = rf.wr_addr[j*REG_ADDR_W +: REG_ADDR_W];
            wd[j] = rf.wr_data[j*XLEN +: XLEN];
            wv[j] = rf.wr_en[j] && reg_valid(wa[j], NREG);
        end
    end

    // Registers touched by a valid write this cycle (drives scoreboard clears).
    always_comb begin
        wr_clr = '0;
        for (int k = 1; k < NREG; k++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wv[j] && (wa[j] == REG_ADDR_W'(k))) begin
                    wr_clr[k] = 1'b1;
                end
            end
        end
    end

    // Per read port: does a valid write hit it, and which data wins (later port overrides).
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_hit[i] = 1'b0;
            byp[i]    = '0;
            for (int j = 0; j < NWR; j++) begin
                if (wv[j] && (wa[j] == rd_a[i])) begin
                    rd_hit[i] = 1'b1;
                    byp[i]    = wd[j];
                end
            end
        end
    end

    // Data array; the highest-index write port lands last and therefore wins a conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 1; k < NREG; k++) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wv[j] && (wa[j] == REG_ADDR_W'(k))) begin
                        regs[k] <= wd[j];
                    end
                end
            end
        end
    end

    // Read muxes with optional forwarding; held at zero while reset is asserted.
    always_comb begin
        rs_data_c = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int k = 1; k < NREG; k++) begin
                if (rd_a[i] == REG_ADDR_W'(k)) begin
                    rs_data_c[i*XLEN +: XLEN] = regs[k];
                end
            end
            if ((BYPASS != 0) && rd_hit[i]) begin
                rs_data_c[i*XLEN +: XLEN] = byp[i];
            end
        end
        if (!rst) begin
            rs_data_c = '0;
        end
    end

    regfile_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (rf.iss_en),
        .iss_addr (rf.iss_addr),
        .flush    (rf.flush),
        .wr_clr   (wr_clr),
        .rs_addr  (rf.rs_addr),
        .rd_hit   (rd_hit),
        .rs_busy  (rs_busy_c)
    );

    assign rf.rs_data = rs_data_c;
    assign rf.rs_busy = rs_busy_c;

endmodule
